// File: rtl/input_loader_if.sv
// Host-side Avalon-MM slave bus plus the three lane streams of the input loader.
// The slave modport is the loader's view; master is the host/lane side.
interface input_loader_if;
    logic       chipselect;
    logic       write;
    logic       read;
    logic [2:0] address;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic [7:0] out_data1;
    logic [7:0] out_data2;
    logic [7:0] out_data3;
    logic       out_valid1;
    logic       out_valid2;
    logic       out_valid3;
    logic       out_ready1;
    logic       out_ready2;
    logic       out_ready3;
    logic       busy;

    modport slave (
        input  chipselect, write, read, address, writedata,
        input  out_ready1, out_ready2, out_ready3,
        output readdata,
        output out_data1, out_data2, out_data3,
        output out_valid1, out_valid2, out_valid3,
        output busy
    );

    modport master (
        output chipselect, write, read, address, writedata,
        output out_ready1, out_ready2, out_ready3,
        input  readdata,
        input  out_data1, out_data2, out_data3,
        input  out_valid1, out_valid2, out_valid3,
        input  busy
    );
endinterface

// File: rtl/input_loader.sv
// Host-to-lane loader: Avalon-MM writes fill three show-ahead byte FIFOs that
// stream to the compute lanes over valid/ready once RUN is set.
module input_loader #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input_loader_if.slave bus
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem    [3][DEPTH];
    logic [AW-1:0] wr_ptr [3];
    logic [AW-1:0] rd_ptr [3];
    logic [AW:0]   count  [3];
    logic [2:0]    ovf;
    logic          run;
    logic [7:0]    readdata_q;

    logic       wr_en;
    logic       rd_en;
    logic       clear;
    logic [2:0] ready;
    logic [2:0] valid;
    logic [2:0] push;
    logic [2:0] pop;
    logic [2:0] accept;

    assign wr_en = bus.chipselect && bus.write;
    assign rd_en = bus.chipselect && bus.read;
    assign clear = wr_en && (bus.address == 3'd0) && bus.writedata[1];
    assign ready = {bus.out_ready3, bus.out_ready2, bus.out_ready1};

    // A push at full is still accepted when the same cycle frees a slot.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            valid[i]  = run && (count[i] != '0);
            pop[i]    = valid[i] && ready[i];
            push[i]   = wr_en && (bus.address == 3'(i + 1));
            accept[i] = push[i] && ((count[i] < FULL) || pop[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run <= 1'b0;
            ovf <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            if (wr_en && (bus.address == 3'd0)) begin
                run <= bus.writedata[0];
            end
            for (int unsigned i = 0; i < 3; i++) begin
                // CLEAR overrides any pop occurring on the same edge.
                if (clear) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                    count[i]  <= '0;
                    ovf[i]    <= 1'b0;
                end else begin
                    if (accept[i]) begin
                        wr_ptr[i] <= wr_ptr[i] + 1'b1;
                    end
                    if (pop[i]) begin
                        rd_ptr[i] <= rd_ptr[i] + 1'b1;
                    end
                    if (accept[i] && !pop[i]) begin
                        count[i] <= count[i] + 1'b1;
                    end else if (!accept[i] && pop[i]) begin
                        count[i] <= count[i] - 1'b1;
                    end
                    if (push[i] && !accept[i]) begin
                        ovf[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 3; i++) begin
            if (accept[i]) begin
                mem[i][wr_ptr[i]] <= bus.writedata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else if (rd_en) begin
            case (bus.address)
                3'd0:                readdata_q <= {7'b0, run};
                3'd1, 3'd2, 3'd3:    readdata_q <= 8'hFC;
                3'd4:                readdata_q <= 8'(count[0]);
                3'd5:                readdata_q <= 8'(count[1]);
                3'd6:                readdata_q <= 8'(count[2]);
                default:             readdata_q <= {5'b0, ovf};
            endcase
        end
    end

    // Head byte is masked while empty so stale memory never shows after reset/CLEAR.
    assign bus.out_data1  = (count[0] != '0) ? mem[0][rd_ptr[0]] : '0;
    assign bus.out_data2  = (count[1] != '0) ? mem[1][rd_ptr[1]] : '0;
    assign bus.out_data3  = (count[2] != '0) ? mem[2][rd_ptr[2]] : '0;
    assign bus.out_valid1 = valid[0];
    assign bus.out_valid2 = valid[1];
    assign bus.out_valid3 = valid[2];
    assign bus.readdata   = readdata_q;
    assign bus.busy       = (count[0] != '0) || (count[1] != '0) || (count[2] != '0);

endmodule

// File: tb/tb_input_loader.sv
// Directed self-checking bench for input_loader: register map, preload/stream,
// overflow, lane backpressure, pointer wrap, CLEAR and async reset.
module tb_input_loader;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    input_loader_if bus();

    input_loader #(.DEPTH(64), .AW(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic read_chk(input logic [2:0] a, input logic [7:0] exp, input string tag);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        chk(tag, {24'b0, bus.readdata}, {24'b0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   got;
        int   exp5;
        logic was_stalled;
        logic [7:0] held;

        reset_n        = 1'b0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        bus.out_ready1 = 1'b0;
        bus.out_ready2 = 1'b0;
        bus.out_ready3 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", {29'b0, bus.out_valid3, bus.out_valid2, bus.out_valid1}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_readdata", {24'b0, bus.readdata}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        read_chk(3'd4, 8'h00, "rst_cnt1");
        read_chk(3'd5, 8'h00, "rst_cnt2");
        read_chk(3'd6, 8'h00, "rst_cnt3");
        read_chk(3'd7, 8'h00, "rst_ovf");
        read_chk(3'd0, 8'h00, "rst_ctrl");
        read_chk(3'd2, 8'hFC, "wo_data2");

        // Preload with RUN=0, then start lane 1
        write_reg(3'd1, 8'h11);
        write_reg(3'd1, 8'h22);
        write_reg(3'd1, 8'h33);
        read_chk(3'd4, 8'h03, "pre_cnt1");
        chk("pre_valid1", {31'b0, bus.out_valid1}, 32'd0);
        chk("pre_busy", {31'b0, bus.busy}, 32'd1);
        chk("pre_head1", {24'b0, bus.out_data1}, 32'h11);
        bus.out_ready1 = 1'b1;
        write_reg(3'd0, 8'h01);
        chk("run_valid1", {31'b0, bus.out_valid1}, 32'd1);
        chk("run_d0", {24'b0, bus.out_data1}, 32'h11);
        @(negedge clk);
        chk("run_d1", {24'b0, bus.out_data1}, 32'h22);
        @(negedge clk);
        chk("run_d2", {24'b0, bus.out_data1}, 32'h33);
        @(negedge clk);
        chk("run_empty1", {31'b0, bus.out_valid1}, 32'd0);
        bus.out_ready1 = 1'b0;
        read_chk(3'd4, 8'h00, "run_cnt1");
        read_chk(3'd0, 8'h01, "run_ctrl");

        // Overflow on lane 2
        for (int k = 0; k < 64; k++) write_reg(3'd2, 8'(k));
        write_reg(3'd2, 8'hAA);
        read_chk(3'd5, 8'd64, "full_cnt2");
        read_chk(3'd7, 8'h02, "full_ovf");
        @(negedge clk);
        chk("rd_hold", {24'b0, bus.readdata}, 32'h02);
        bus.out_ready2 = 1'b1;
        write_reg(3'd2, 8'hBB);
        bus.out_ready2 = 1'b0;
        read_chk(3'd5, 8'd64, "fullpop_cnt2");
        read_chk(3'd7, 8'h02, "fullpop_ovf");
        bus.out_ready2 = 1'b1;
        for (int k = 0; k < 64; k++) begin
            chk("drain2", {24'b0, bus.out_data2}, (k < 63) ? 32'(k + 1) : 32'hBB);
            @(negedge clk);
        end
        bus.out_ready2 = 1'b0;
        chk("drain2_empty", {31'b0, bus.out_valid2}, 32'd0);

        // Lane 3 with ready pattern 1,0,1,1
        for (int k = 0; k < 8; k++) write_reg(3'd3, 8'(k));
        got = 0;
        was_stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            bus.out_ready3 = ((c % 4) != 1);
            if (was_stalled) chk("l3_hold", {24'b0, bus.out_data3}, {24'b0, held});
            was_stalled = 1'b0;
            if (bus.out_valid3) begin
                if (bus.out_ready3) begin
                    chk("l3_order", {24'b0, bus.out_data3}, 32'(got));
                    got++;
                end else begin
                    held = bus.out_data3;
                    was_stalled = 1'b1;
                end
            end
            @(negedge clk);
        end
        bus.out_ready3 = 1'b0;
        chk("l3_total", 32'(got), 32'd8);
        chk("l3_empty", {31'b0, bus.out_valid3}, 32'd0);

        // Pointer wrap: 200 push/pop pairs on lane 1
        exp5 = 0;
        bus.out_ready1 = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (bus.out_valid1) begin
                chk("wrap_data", {24'b0, bus.out_data1}, {24'b0, 8'(exp5 + 200)});
                exp5++;
            end
            bus.chipselect = 1'b1;
            bus.write      = 1'b1;
            bus.address    = 3'd1;
            bus.writedata  = 8'(n + 200);
            @(negedge clk);
        end
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (bus.out_valid1) begin
                chk("wrap_tail", {24'b0, bus.out_data1}, {24'b0, 8'(exp5 + 200)});
                exp5++;
            end
            @(negedge clk);
        end
        bus.out_ready1 = 1'b0;
        chk("wrap_total", 32'(exp5), 32'd200);
        read_chk(3'd4, 8'h00, "wrap_cnt1");

        // CLEAR + RUN while every lane handshakes
        for (int k = 0; k < 5; k++) begin
            write_reg(3'd1, 8'(k));
            write_reg(3'd2, 8'(k));
            write_reg(3'd3, 8'(k));
        end
        read_chk(3'd6, 8'd5, "clr_pre_cnt3");
        bus.out_ready1 = 1'b1;
        bus.out_ready2 = 1'b1;
        bus.out_ready3 = 1'b1;
        write_reg(3'd0, 8'h03);
        chk("clr_valid", {29'b0, bus.out_valid3, bus.out_valid2, bus.out_valid1}, 32'd0);
        bus.out_ready1 = 1'b0;
        bus.out_ready2 = 1'b0;
        bus.out_ready3 = 1'b0;
        read_chk(3'd4, 8'h00, "clr_cnt1");
        read_chk(3'd5, 8'h00, "clr_cnt2");
        read_chk(3'd6, 8'h00, "clr_cnt3");
        read_chk(3'd7, 8'h00, "clr_ovf");
        read_chk(3'd0, 8'h01, "clr_ctrl");

        // Asynchronous reset mid-stream
        write_reg(3'd1, 8'h5A);
        write_reg(3'd1, 8'h5B);
        chk("ar_valid_pre", {31'b0, bus.out_valid1}, 32'd1);
        chk("ar_data_pre", {24'b0, bus.out_data1}, 32'h5A);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, bus.out_valid1}, 32'd0);
        chk("ar_data", {24'b0, bus.out_data1}, 32'd0);
        chk("ar_busy", {31'b0, bus.busy}, 32'd0);
        chk("ar_readdata", {24'b0, bus.readdata}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        read_chk(3'd0, 8'h00, "ar_ctrl");
        read_chk(3'd4, 8'h00, "ar_cnt1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_loader.md
Name: input_loader

Overview:
- Host-to-pipeline direction of the result-capture path: the host writes operand bytes over the Avalon-MM slave port into three per-channel FIFOs.
- Once the host sets RUN, the block streams the bytes to the three compute lanes with a valid/ready handshake.
- It sits between the HPS bridge and the compute lanes, mirroring the capture buffer that returns lane results to the host.

Parameters:
- DEPTH, 64, entries per channel FIFO; power of two, 2..128.
- AW, 6, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe; qualified by chipselect.
- read  in  1  Avalon read strobe; qualified by chipselect.
- address  in  3  Avalon register index.
- writedata  in  8  Avalon write data.
- readdata  out  8  Avalon read data; valid 1 cycle after the read strobe.
- out_data1, out_data2, out_data3  out  8 each  head byte of FIFO n.
- out_valid1, out_valid2, out_valid3  out  1 each  lane n has a byte available.
- out_ready1, out_ready2, out_ready3  in  1 each  lane n accepts the byte.
- busy  out  1  any FIFO non-empty.

Behaviour:
- Reset (async assert, sync release):
  - all FIFO counts and pointers 0; RUN=0; overflow flags 0.
  - readdata=0; out_valid*=0; out_data*=0; busy=0.
- Register map for writes (chipselect&&write):
  - addr 0: CTRL. bit0 loads RUN. bit1=CLEAR is self-clearing: flushes all three FIFOs (pointers and counts to 0) and clears the overflow flags in that same edge.
  - addr 1/2/3: push writedata into FIFO 1/2/3.
  - addr 4..7: writes ignored.
- Register map for reads (chipselect&&read), registered, 1-cycle latency:
  - addr 0: {7'b0, RUN}
  - addr 1/2/3: 8'hFC (write-only)
  - addr 4/5/6: count of FIFO 1/2/3, zero-extended
  - addr 7: {5'b0, ovf3, ovf2, ovf1}
  - When no read is in progress, readdata holds its last value.
- FIFO (one per channel, identical): show-ahead. out_data = mem[rd_ptr] and reflects the head combinationally from registered pointers.
  - out_valid = RUN && (count != 0).
  - Pop on out_valid && out_ready: rd_ptr+1, count-1.
  - Push is accepted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle. On accept: mem[wr_ptr] <= writedata, wr_ptr+1.
  - Push rejected (full, no pop): data dropped, ovfN set. ovfN is sticky until CLEAR or reset.
  - Pointers wrap modulo DEPTH. Count width is AW+1 and never exceeds DEPTH.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push into an empty FIFO: out_valid rises on the next cycle (1-cycle write-to-valid latency). A byte is never presented in the same cycle it is written.
- RUN=0: out_valid*=0 and no pops occur. Pushes are still accepted, so the host can preload before starting.
- RUN 1->0 mid-stream: valid drops on the next edge; the FIFO contents are retained.
- CLEAR while a lane handshakes in the same cycle: CLEAR wins. The pop is discarded and counts become 0.
- CLEAR and RUN in the same write: flush happens and RUN takes bit0.
- Simultaneous read and write in the same cycle: both are serviced. A read returns the pre-edge state (e.g. a count read concurrent with a push reports the old count).
- busy = |{count1, count2, count3} != 0, registered-free (combinational from counts).
- Reset mid-operation: all state returns immediately to reset values and FIFO data is discarded.

Test Plan:
- Reset, then read addr 4,5,6,7 and 0 -> readdata 0 for each, 1 cycle after the strobe. out_valid*=0, busy=0.
- RUN=0, write 0x11,0x22,0x33 to addr 1 -> addr 4 reads 3, out_valid1=0, busy=1. Then write CTRL=0x01 with out_ready1=1 -> out_data1 gives 0x11, 0x22, 0x33 on consecutive cycles, then out_valid1=0 and addr 4 reads 0.
- Fill FIFO 2 with DEPTH=64 bytes, then push a 65th (0xAA) -> addr 5 reads 64, addr 7 reads 0x02, and 0xAA is never emitted. Next, push at full while lane 2 pops -> push accepted, count stays 64, ovf2 unchanged.
- RUN=1 with a toggling out_ready3 pattern 1,0,1,1 over 8 pushed bytes 0..7 -> bytes emitted in order 0..7 with no duplicates or losses; out_data3 is held stable while out_ready3=0.
- Pointer wrap: 200 push/pop pairs on lane 1 with a running counter -> lane 1 outputs the matching sequence modulo 256, with count never exceeding 64.
- With 5 bytes in each FIFO, write CTRL=0x03 while out_ready*=1 -> next cycle addr 4/5/6 read 0, addr 7 reads 0, RUN=1, out_valid*=0. Separately, assert reset_n=0 mid-stream -> outputs go to reset values asynchronously.
